adc_capture: RTL and testbench

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_capture.sv | 98 +++++++++
 tb/tb_adc_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// adc_capture: synchronized ADC capture with decimation, show-ahead sample FIFO, sticky overrun and write counter.
// Optional feature macro ADC_CAPTURE_OFFSET_BIN_EN: invert each sample MSB at capture (offset binary -> two's complement).
module adc_capture #(
    parameter int sig_width  = 12,
    parameter int fifo_depth = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        conv_done,
    input  logic [sig_width-1:0]        adc_in_a,
    input  logic [sig_width-1:0]        adc_in_b,
    input  logic                        enable,
    input  logic [3:0]                  decim,
    output logic [sig_width-1:0]        out_a,
    output logic [sig_width-1:0]        out_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(fifo_depth):0] fifo_level,
    output logic                        overrun,
    input  logic                        clr_overrun,
    output logic [15:0]                 sample_cnt
);
    localparam int pw = $clog2(fifo_depth);
    localparam int lw = pw + 1;
    localparam logic [lw-1:0] full_lvl = lw'(fifo_depth);

    logic [2:0]           sync_q, sync_d;
    logic [3:0]           dcnt_q, dcnt_d;
    logic [pw-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [lw-1:0]        lvl_q, lvl_d;
    logic                 ovr_q, ovr_d;
    logic [15:0]          sample_cnt_q, sample_cnt_d;
    logic [sig_width-1:0] mem_a_q [fifo_depth];
    logic [sig_width-1:0] mem_b_q [fifo_depth];
    logic [sig_width-1:0] msb_flip, cap_a, cap_b;
    logic                 edge_det, kept, full, pop, push, drop;

`ifdef ADC_CAPTURE_OFFSET_BIN_EN
    assign msb_flip = {1'b1, {(sig_width-1){1'b0}}};
`else
    assign msb_flip = '0;
`endif

    assign out_valid  = lvl_q != '0;
    assign out_a      = mem_a_q[rd_q];
    assign out_b      = mem_b_q[rd_q];
    assign fifo_level = lvl_q;
    assign overrun    = ovr_q;
    assign sample_cnt = sample_cnt_q;

    // Edge detect, decimation, FIFO bookkeeping; a full FIFO still accepts a sample when the head pops in the same cycle
    always_comb begin
        sync_d       = {sync_q[1], sync_q[0], conv_done};
        edge_det     = sync_q[1] & ~sync_q[2];
        kept         = edge_det & enable & (dcnt_q == 4'd0);
        full         = lvl_q == full_lvl;
        pop          = out_valid & out_ready;
        push         = kept & (~full | pop);
        drop         = kept & full & ~pop;
        dcnt_d       = ~enable ? 4'd0 : edge_det ? ((dcnt_q >= decim) ? 4'd0 : dcnt_q + 4'd1) : dcnt_q;
        wr_d         = wr_q + pw'(push);
        rd_d         = rd_q + pw'(pop);
        lvl_d        = lvl_q + lw'(push) - lw'(pop);
        ovr_d        = drop | (ovr_q & ~clr_overrun);
        sample_cnt_d = sample_cnt_q + 16'(push);
        cap_a        = adc_in_a ^ msb_flip;
        cap_b        = adc_in_b ^ msb_flip;
    end

    // State registers; synchronizer resets high so a conv_done held through reset is not a capture edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '1;
            dcnt_q       <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            lvl_q        <= '0;
            ovr_q        <= 1'b0;
            sample_cnt_q <= '0;
            for (int i = 0; i < fifo_depth; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else begin
            sync_q       <= sync_d;
            dcnt_q       <= dcnt_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            lvl_q        <= lvl_d;
            ovr_q        <= ovr_d;
            sample_cnt_q <= sample_cnt_d;
            if (push) begin
                mem_a_q[wr_q] <= cap_a;
                mem_b_q[wr_q] <= cap_b;
            end
        end
    end
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed bench for adc_capture with a scoreboard of expected FIFO output samples.
module tb_adc_capture;
    logic        clk = 1'b0;
    logic        rst, conv_done, enable, out_ready, clr_overrun, out_valid, overrun;
    logic [11:0] adc_in_a, adc_in_b, out_a, out_b;
    logic [3:0]  decim;
    logic [2:0]  fifo_level;
    logic [15:0] sample_cnt;
    logic [23:0] sb [$];
    logic [23:0] mon_e;
    int          n_tests = 0;
    int          n_fail = 0;
    int          exp_cnt = 0;

    adc_capture dut (
        .clk(clk), .rst(rst), .conv_done(conv_done), .adc_in_a(adc_in_a), .adc_in_b(adc_in_b),
        .enable(enable), .decim(decim), .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level), .overrun(overrun),
        .clr_overrun(clr_overrun), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] cv(input logic [11:0] x);
`ifdef ADC_CAPTURE_OFFSET_BIN_EN
        return x ^ 12'h800;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // conv_done high 4 cycles then low 4; capture lands on the 3rd edge, optionally with a pop at that edge
    task automatic pulse(input logic [11:0] a, input logic [11:0] b, input bit pop_cap);
        adc_in_a  = a;
        adc_in_b  = b;
        conv_done = 1'b1;
        repeat (2) step();
        if (pop_cap) out_ready = 1'b1;
        step();
        if (pop_cap) out_ready = 1'b0;
        step();
        conv_done = 1'b0;
        repeat (4) step();
    endtask

    task automatic expect_sample(input logic [11:0] a, input logic [11:0] b);
        sb.push_back({cv(a), cv(b)});
        exp_cnt++;
    endtask

    // Scoreboard consumer: every accepted head sample must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed pop of %0h/%0h expected none", out_a, out_b);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("pop_a", 32'(out_a), 32'(mon_e[23:12]));
                chk("pop_b", 32'(out_b), 32'(mon_e[11:0]));
            end
        end
    end

    initial begin
        rst = 1'b1; conv_done = 1'b0; adc_in_a = '0; adc_in_b = '0;
        enable = 1'b1; decim = 4'd0; out_ready = 1'b0; clr_overrun = 1'b0;
        repeat (3) step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_cnt", 32'(sample_cnt), 0);
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_out_b", 32'(out_b), 0);
        rst = 1'b0;
        step();

        adc_in_a = 12'h123; adc_in_b = 12'hABC; conv_done = 1'b1;
        step(); chk("lat_k", 32'(out_valid), 0);
        step(); chk("lat_k1", 32'(out_valid), 0);
        step(); chk("lat_k2", 32'(out_valid), 1);
        expect_sample(12'h123, 12'hABC);
        chk("single_a", 32'(out_a), 32'(cv(12'h123)));
        chk("single_b", 32'(out_b), 32'(cv(12'hABC)));
        chk("single_cnt", 32'(sample_cnt), 32'(exp_cnt));
        chk("single_level", 32'(fifo_level), 1);
        conv_done = 1'b0;
        repeat (3) step();
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("single_drained", 32'(out_valid), 0);

        decim = 4'd3; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) expect_sample(12'(i), 12'(i + 100));
            pulse(12'(i), 12'(i + 100), 1'b0);
        end
        chk("dec_cnt", 32'(sample_cnt), 32'(exp_cnt));
        chk("dec_sb_empty", 32'(sb.size()), 0);
        chk("dec_valid", 32'(out_valid), 0);

        decim = 4'd0; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_sample(12'(32'h200 + i), 12'(32'h600 + i));
            pulse(12'(32'h200 + i), 12'(32'h600 + i), 1'b0);
        end
        chk("ovr_level", 32'(fifo_level), 4);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_cnt", 32'(sample_cnt), 32'(exp_cnt));
        chk("ovr_head_a", 32'(out_a), 32'(cv(12'h200)));
        chk("ovr_head_b", 32'(out_b), 32'(cv(12'h600)));
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);
        chk("ovr_clr_level", 32'(fifo_level), 4);

        expect_sample(12'h300, 12'h700);
        pulse(12'h300, 12'h700, 1'b1);
        chk("fullpop_level", 32'(fifo_level), 4);
        chk("fullpop_overrun", 32'(overrun), 0);
        chk("fullpop_cnt", 32'(sample_cnt), 32'(exp_cnt));
        out_ready = 1'b1; repeat (6) step(); out_ready = 1'b0;
        chk("fullpop_sb_empty", 32'(sb.size()), 0);
        chk("fullpop_level0", 32'(fifo_level), 0);

        enable = 1'b0;
        pulse(12'h055, 12'h066, 1'b0);
        chk("dis_level", 32'(fifo_level), 0);
        chk("dis_cnt", 32'(sample_cnt), 32'(exp_cnt));
        enable = 1'b1;

        pulse(12'h0A1, 12'h0C1, 1'b0);
        pulse(12'h0A2, 12'h0C2, 1'b0);
        chk("pre_rst_level", 32'(fifo_level), 2);
        conv_done = 1'b1;
        step();
        rst = 1'b1; repeat (2) step(); rst = 1'b0;
        exp_cnt = 0;
        repeat (5) step();
        chk("post_rst_valid", 32'(out_valid), 0);
        chk("post_rst_level", 32'(fifo_level), 0);
        chk("post_rst_cnt", 32'(sample_cnt), 0);
        conv_done = 1'b0;
        repeat (4) step();
        chk("post_rst_low_level", 32'(fifo_level), 0);
        expect_sample(12'h0B1, 12'h0B2);
        pulse(12'h0B1, 12'h0B2, 1'b0);
        chk("post_rst_cap_level", 32'(fifo_level), 1);
        chk("post_rst_cap_cnt", 32'(sample_cnt), 32'(exp_cnt));
        out_ready = 1'b1; step(); out_ready = 1'b0;

        force dut.sample_cnt_q = 16'hFFFE;
        step();
        release dut.sample_cnt_q;
        step();
        chk("wrap_preload", 32'(sample_cnt), 32'h0000_FFFE);
        out_ready = 1'b1;
        sb.push_back({cv(12'h0D1), cv(12'h0E1)});
        pulse(12'h0D1, 12'h0E1, 1'b0);
        chk("wrap_ffff", 32'(sample_cnt), 32'h0000_FFFF);
        sb.push_back({cv(12'h0D2), cv(12'h0E2)});
        pulse(12'h0D2, 12'h0E2, 1'b0);
        chk("wrap_zero", 32'(sample_cnt), 0);
        out_ready = 1'b0;
        chk("final_sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
